uart_wb_master: RTL and testbench

//  Wishbone initiator that drives the UART register slave (TX 0x0, RX 0x1, DIV 0x2) from a local command stream.

---
 rtl/uart_wb_master.sv | 201 ++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_master.sv
// uart_wb_master: Wishbone initiator for the UART register slave.
// Queues local register commands in a small FIFO and runs each one as a
// 4-phase stb/ack bus cycle. Every popped command produces exactly one
// response pulse, which carries either the read data or a timeout error.
module uart_wb_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic       wb_clk,
    input  logic       reset,
    // local command stream
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    // response stream (no backpressure)
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       rsp_read,
    output logic       busy,
    // Wishbone initiator side
    output logic       wb_stb,
    output logic       wb_we,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack
);

    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = AW + 1;
    // The timer only has to reach TIMEOUT-1 before it either fires or saturates.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TMR_MAX  = '1;
    localparam bit            TMO_EN   = (TIMEOUT != 0);

    typedef struct packed {
        logic       write;
        logic [1:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } state_t;

    state_t        state, state_n;
    cmd_t          fifo_mem [CMD_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [TW-1:0] timer, timer_n;

    logic          stb_n, we_n;
    logic [1:0]    addr_n;
    logic [7:0]    dat_n;
    logic          rsp_valid_n, rsp_err_n, rsp_read_n;
    logic [7:0]    rsp_data_n;

    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // FIFO storage: written on every accepted command.
    // NOTE: the storage array has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge wb_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, data: cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as CMD_DEPTH is a power of 2.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state, pop decision and next values of all registered bus/response outputs.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        timer_n     = timer;
        stb_n       = wb_stb;
        we_n        = wb_we;
        addr_n      = wb_addr;
        dat_n       = wb_dat_o;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        rsp_read_n  = rsp_read;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    addr_n  = head.addr;
                    dat_n   = head.data;
                    we_n    = !head.write;   // slave polarity: low means write
                    stb_n   = 1'b1;
                    timer_n = '0;
                    state_n = REQ;
                end
            end

            REQ: begin
                if (wb_ack) begin
                    // A stale ack present on entry is accepted as the acknowledge.
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_read_n  = wb_we;
                    rsp_data_n  = wb_we ? wb_dat_i : 8'h00;
                    timer_n     = '0;
                    state_n     = REL;
                end else if (TMO_EN && (timer == TMO_LAST)) begin
                    stb_n       = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_read_n  = wb_we;
                    rsp_data_n  = 8'h00;
                    timer_n     = '0;
                    state_n     = REL;
                end else if (timer != TMR_MAX) begin
                    timer_n = timer + TW'(1);
                end
            end

            REL: begin
                stb_n = 1'b0;
                if (!wb_ack) begin
                    state_n = IDLE;
                end else if (TMO_EN && (timer == TMO_LAST)) begin
                    // Slave never released ack: give up silently, response already sent.
                    timer_n = '0;
                    state_n = IDLE;
                end else if (timer != TMR_MAX) begin
                    timer_n = timer + TW'(1);
                end
            end

            default: begin
                stb_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // Registered bus outputs, response outputs and the ack-wait timer.
    always_ff @(posedge wb_clk) begin
        if (reset) begin
            wb_stb    <= 1'b0;
            wb_we     <= 1'b1;
            wb_addr   <= '0;
            wb_dat_o  <= '0;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_read  <= 1'b0;
        end else begin
            wb_stb    <= stb_n;
            wb_we     <= we_n;
            wb_addr   <= addr_n;
            wb_dat_o  <= dat_n;
            timer     <= timer_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            rsp_read  <= rsp_read_n;
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: scoreboard bench for uart_wb_master.
// The reference model is a 4-entry register file: each accepted command
// produces its expected response (and expected bus transfer) at push time.
// A slave model answers the bus; a monitor pops and compares responses.
module tb_uart_wb_master;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       wb_clk = 1'b0;
    logic       reset  = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [1:0] cmd_addr  = '0;
    logic [7:0] cmd_data  = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_read;
    logic       busy;
    logic       wb_stb;
    logic       wb_we;
    logic [1:0] wb_addr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = '0;
    logic       wb_ack   = 1'b0;

    uart_wb_master #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .wb_clk    (wb_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_read  (rsp_read),
        .busy      (busy),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack    (wb_ack)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic       read;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_t;

    rsp_t       exp_rsp[$];
    bus_t       exp_bus[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_regs [4];
    logic [7:0] slv_regs [4];
    bit         no_ack      = 1'b0;
    int         fixed_delay = -1;
    int         slv_cnt     = 0;
    int         slv_delay   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: 4-phase, acks slv_delay cycles after stb, drops ack when stb drops.
    always @(negedge wb_clk) begin
        bus_t b;
        if (reset || !wb_stb) begin
            wb_ack   = 1'b0;
            slv_cnt  = 0;
            wb_dat_i = 8'($urandom);
        end else if (!wb_ack && !no_ack) begin
            if (slv_cnt == 0)
                slv_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 5));
            if (slv_cnt >= slv_delay) begin
                wb_ack   = 1'b1;
                wb_dat_i = slv_regs[wb_addr];
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    b = exp_bus.pop_front();
                    check("bus_we",   32'(wb_we),   32'(b.we));
                    check("bus_addr", 32'(wb_addr), 32'(b.addr));
                    if (!b.we) check("bus_wdata", 32'(wb_dat_o), 32'(b.data));
                end
                if (!wb_we) slv_regs[wb_addr] = wb_dat_o;
            end else begin
                slv_cnt++;
            end
        end
    end

    // Monitor: bus stability during a cycle, strobe length on timeout, response scoreboard.
    int         run_len  = 0;
    int         last_run = 0;
    logic [10:0] held_bus = '0;
    always @(negedge wb_clk) begin
        rsp_t r;
        if (reset) begin
            run_len = 0;
        end else begin
            if (wb_stb) begin
                if (run_len > 0)
                    check("stb_hold", 32'({wb_we, wb_addr, wb_dat_o}), 32'(held_bus));
                held_bus = {wb_we, wb_addr, wb_dat_o};
                run_len++;
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_read", 32'(rsp_read), 32'(r.read));
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                    check("rsp_err",  32'(rsp_err),  32'(r.err));
                    if (r.err) check("tmo_stb_len", 32'(last_run), 32'(TMO));
                end
            end
        end
    end

    // Offer one command starting at the current negedge; returns at the negedge after acceptance.
    task automatic send(input bit wr, input logic [1:0] a, input logic [7:0] d);
        int   n = 0;
        rsp_t r;
        bus_t b;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(negedge wb_clk);
            n++;
        end
        if (!cmd_ready) begin
            check("send_accept", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (no_ack) begin
            r = '{read: !wr, data: 8'h00, err: 1'b1};
        end else begin
            r = '{read: !wr, data: (wr ? 8'h00 : ref_regs[a]), err: 1'b0};
            b = '{we: !wr, addr: a, data: d};
            exp_bus.push_back(b);
            if (wr) ref_regs[a] = d;
        end
        exp_rsp.push_back(r);
        @(negedge wb_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || exp_rsp.size() != 0) && n < 600) begin
            @(negedge wb_clk);
            n++;
        end
        check(name, 32'(busy || (exp_rsp.size() != 0)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] saved [4];
        int n;

        slv_regs = '{8'h11, 8'h5A, 8'h33, 8'h44};
        ref_regs = '{8'h11, 8'h5A, 8'h33, 8'h44};

        // Reset state
        repeat (2) @(negedge wb_clk);
        check("rst_stb",       32'(wb_stb),    32'd0);
        check("rst_we",        32'(wb_we),     32'd1);
        check("rst_addr",      32'(wb_addr),   32'd0);
        check("rst_dat_o",     32'(wb_dat_o),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_read",  32'(rsp_read),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_ready",     32'(cmd_ready), 32'd1);
        reset = 1'b0;
        @(negedge wb_clk);

        // Write DIV=0x0A, then read RX (0x5A), slave acks 2 cycles after stb
        fixed_delay = 2;
        send(1'b1, 2'd2, 8'h0A);
        drain("drain_write");
        send(1'b0, 2'd1, 8'hFF);
        drain("drain_read");

        // Launch latency: accepted at E onto an empty FIFO -> stb high only after E+1
        send(1'b0, 2'd3, 8'h00);
        check("lat_after_e",  32'(wb_stb), 32'd0);
        check("lat_busy",     32'(busy),   32'd1);
        @(negedge wb_clk);
        check("lat_after_e1", 32'(wb_stb), 32'd1);
        drain("drain_lat");

        // Fill while the slave is slow: 1 in flight + DEPTH queued, then refuse
        fixed_delay = 6;
        for (int i = 0; i <= DEPTH; i++)
            send($urandom_range(0, 1) == 1, 2'($urandom), 8'($urandom));
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_busy",  32'(busy),      32'd1);
        send(1'b0, 2'd2, 8'h00);
        drain("drain_full");

        // Push on the same edge as a pop with DEPTH-1 queued
        send(1'b1, 2'd0, 8'hA1);
        send(1'b1, 2'd1, 8'hB2);
        send(1'b0, 2'd0, 8'h00);
        send(1'b1, 2'd3, 8'hC3);
        n = 0;
        while (wb_stb && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        check("samedge_rel", 32'(wb_stb), 32'd0);
        @(negedge wb_clk);
        send(1'b0, 2'd1, 8'h00);
        check("samedge_ready",  32'(cmd_ready), 32'd1);
        check("samedge_launch", 32'(wb_stb),    32'd1);
        send(1'b0, 2'd3, 8'h00);
        check("samedge_full",   32'(cmd_ready), 32'd0);
        drain("drain_samedge");

        // Slave never acks: each command times out after TMO strobe cycles
        fixed_delay = -1;
        no_ack = 1'b1;
        send(1'b1, 2'd0, 8'h77);
        send(1'b0, 2'd2, 8'h00);
        drain("drain_timeout");

        // Reset mid-cycle with two commands queued: everything discarded silently
        saved = ref_regs;
        send(1'b0, 2'd1, 8'h00);
        send(1'b1, 2'd2, 8'h99);
        send(1'b0, 2'd3, 8'h00);
        check("rst_mid_pre_stb", 32'(wb_stb), 32'd1);
        reset = 1'b1;
        exp_rsp.delete();
        exp_bus.delete();
        ref_regs = saved;
        @(negedge wb_clk);
        check("rst_mid_stb",   32'(wb_stb),    32'd0);
        check("rst_mid_busy",  32'(busy),      32'd0);
        check("rst_mid_rsp",   32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        reset  = 1'b0;
        no_ack = 1'b0;
        repeat (12) @(negedge wb_clk);
        check("rst_rel_stb",  32'(wb_stb), 32'd0);
        check("rst_rel_busy", 32'(busy),   32'd0);

        // Randomized traffic with random slave latency and idle gaps
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 1) == 1, 2'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge wb_clk);
        end
        drain("drain_random");
        check("bus_left", 32'(exp_bus.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
